// File: rtl/button_input_bank_pkg.sv
// Shared constants for the button input bank: status bus layout and channel limit.
package button_input_bank_pkg;
    localparam int BTN_BUS_W   = 8;
    localparam int BTN_OVR_BIT = 7;
    localparam int BTN_MAX_CH  = 7;

    typedef logic [BTN_BUS_W-1:0] btn_status_t;
endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, polarity fix, stability counter,
// debounced state and a registered press pulse on each 0->1 of that state.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic stable_o,
    output logic press_o
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic          REL  = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          synced;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic          hit;
    logic [CW-1:0] cnt_q, cnt_d;

    // Inversion sits after the second flop so the flops reset to the raw idle level.
    assign synced = sync_q[1] ^ REL;

    always_comb begin
        hit      = (synced != stable_q) && (cnt_q == LAST);
        cnt_d    = ((synced == stable_q) || hit) ? '0 : cnt_q + CW'(1);
        stable_d = stable_q ^ hit;
        press_d  = hit & ~stable_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= {2{REL}};
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;
endmodule

// File: rtl/button_input_bank.sv
// Bank of debounced buttons presented as one memory-mapped status byte,
// either as sticky press events with clear-on-read or as live levels.
module button_input_bank
    import button_input_bank_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 0,
    parameter int LATCH_MODE      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BTN-1:0]     btn,
    input  logic                 button_read,
    output logic [BTN_BUS_W-1:0] button_op
);
    if (N_BTN < 1 || N_BTN > BTN_MAX_CH) begin : g_bad_n
        $error("button_input_bank: N_BTN must be 1..7");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("button_input_bank: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] status_bits;
    logic             ovr_bit;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_db (
            .clk_i     (clk),
            .rst_ni    (reset),
            .btn_raw_i (btn[g]),
            .stable_o  (stable[g]),
            .press_o   (press[g])
        );
    end

    if (LATCH_MODE != 0) begin : g_latch
        logic [N_BTN-1:0] pend_q, pend_d;
        logic             ovr_q, ovr_d;
        logic             rd_q;
        logic             read_rise;
        logic             unused_stable;

        assign unused_stable = ^stable;
        assign read_rise     = button_read & ~rd_q;

        // A press landing on the clearing edge wins, so the bit is never lost;
        // a press onto an already-pending bit is a lost event regardless of the read.
        always_comb begin
            pend_d = (pend_q & ~{N_BTN{read_rise}}) | press;
            ovr_d  = (ovr_q & ~read_rise) | (|(press & pend_q));
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pend_q <= '0;
                ovr_q  <= 1'b0;
                rd_q   <= 1'b0;
            end else begin
                pend_q <= pend_d;
                ovr_q  <= ovr_d;
                rd_q   <= button_read;
            end
        end

        assign status_bits = pend_q;
        assign ovr_bit     = ovr_q;
    end else begin : g_level
        logic unused_level;

        assign unused_level = ^{button_read, press};
        assign status_bits  = stable;
        assign ovr_bit      = 1'b0;
    end

    always_comb begin
        button_op              = '0;
        button_op[N_BTN-1:0]   = status_bits;
        button_op[BTN_OVR_BIT] = ovr_bit;
    end
endmodule

// File: tb/tb_button_input_bank.sv
// Bench for button_input_bank: a latch-mode bank and an active-low level-mode
// bank, both checked every cycle against a sample-window model of the rules.
module tb_button_input_bank;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn_a;
    logic       read_a;
    logic [7:0] op_a;
    logic [2:0] btn_b;
    logic       read_b;
    logic [7:0] op_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_input_bank #(
        .N_BTN(2), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(0), .LATCH_MODE(1)
    ) u_latch (
        .clk(clk), .reset(reset), .btn(btn_a), .button_read(read_a), .button_op(op_a)
    );

    button_input_bank #(
        .N_BTN(3), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .LATCH_MODE(0)
    ) u_level (
        .clk(clk), .reset(reset), .btn(btn_b), .button_read(read_b), .button_op(op_b)
    );

    // Model: hist[i][0] is the pressed-level sampled at the previous edge. The
    // debounced state flips at an edge when the DC samples taken 2..DC+1 edges
    // earlier all disagree with it.
    logic [2:0] m_hist [2][DC+1];
    logic [2:0] m_st   [2];
    logic [2:0] m_tog  [2];
    logic [2:0] m_lvl  [2];
    logic [1:0] m_pend, m_pq, m_newp;
    logic       m_ovr, m_rdp, m_rr;
    logic [7:0] exp_a, exp_b;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j <= DC; j++) m_hist[i][j] = '0;
            m_st[i] = '0;
        end
        m_pend = '0; m_pq = '0; m_ovr = 1'b0; m_rdp = 1'b0;
        exp_a = 8'h00; exp_b = 8'h00;
    endtask

    task automatic model_step();
        m_lvl[0] = {1'b0, btn_a};
        m_lvl[1] = ~btn_b;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) begin
                m_tog[i][c] = 1'b1;
                for (int j = 1; j <= DC; j++)
                    if (m_hist[i][j][c] == m_st[i][c]) m_tog[i][c] = 1'b0;
            end
        end
        m_newp = m_tog[0][1:0] & ~m_st[0][1:0];
        for (int i = 0; i < 2; i++) m_st[i] = m_st[i] ^ m_tog[i];
        m_rr   = read_a & ~m_rdp;
        m_rdp  = read_a;
        m_ovr  = (m_ovr & ~m_rr) | (|(m_pq & m_pend));
        m_pend = (m_pend & ~{2{m_rr}}) | m_pq;
        m_pq   = m_newp;
        for (int i = 0; i < 2; i++) begin
            for (int j = DC; j >= 1; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = m_lvl[i];
        end
        exp_a = {m_ovr, 5'b0, m_pend};
        exp_b = {5'b0, m_st[1]};
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        chk("model_latch", op_a, exp_a);
        chk("model_level", op_b, exp_b);
    endtask

    task automatic tickc(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        tick();
        chk({tag, "_a"}, op_a, ea);
        chk({tag, "_b"}, op_b, eb);
    endtask

    initial begin
        int n;
        reset  = 1'b0;
        btn_a  = 2'($urandom);
        btn_b  = 3'($urandom);
        read_a = 1'b0;
        read_b = 1'b0;
        model_reset();
        #2;
        chk("rst_async_a", op_a, 8'h00);
        chk("rst_async_b", op_b, 8'h00);
        repeat (3) begin
            @(negedge clk);
            btn_a = 2'($urandom);
            btn_b = 3'($urandom);
            chk("rst_hold_a", op_a, 8'h00);
        end
        @(negedge clk);
        btn_a = 2'b00;
        btn_b = 3'b111;
        reset = 1'b1;
        repeat (10) tickc("idle", 8'h00, 8'h00);

        // Clean press on channel 0, then a one-cycle read.
        btn_a = 2'b01;
        repeat (6) tickc("press_early", 8'h00, 8'h00);
        tickc("press_edge7", 8'h01, 8'h00);
        read_a = 1'b1;
        #1 chk("read_sample", op_a, 8'h01);
        tick();
        read_a = 1'b0;
        chk("read_cleared", op_a, 8'h00);

        // Glitches on channel 1 shorter than the debounce window.
        for (int k = 0; k < 8; k++) begin
            btn_a[1] = (k != 3 && k != 7);
            tickc("glitch", 8'h00, 8'h00);
        end
        repeat (4) tickc("glitch_tail", 8'h00, 8'h00);
        btn_a[1] = 1'b1;
        repeat (3) tickc("glitch_tail2", 8'h00, 8'h00);
        btn_a = 2'b00;
        repeat (8) tickc("release", 8'h00, 8'h00);

        // Overrun: two presses without a read.
        btn_a = 2'b01;
        repeat (8) tick();
        btn_a = 2'b00;
        repeat (8) tick();
        btn_a = 2'b01;
        repeat (8) tick();
        chk("overrun", op_a, 8'h81);
        read_a = 1'b1;
        tick();
        read_a = 1'b0;
        chk("overrun_clear", op_a, 8'h00);
        btn_a = 2'b00;
        repeat (8) tick();
        // Held strobe clears once; a press during the hold stays pending.
        read_a = 1'b1;
        repeat (5) tickc("held_read", 8'h00, 8'h00);
        btn_a = 2'b01;
        repeat (6) tick();
        tickc("held_read_press", 8'h01, 8'h00);
        repeat (3) tickc("held_read_keep", 8'h01, 8'h00);
        read_a = 1'b0;
        tick();
        read_a = 1'b1;
        tick();
        read_a = 1'b0;
        btn_a = 2'b00;
        repeat (8) tickc("after_clear", 8'h00, 8'h00);

        // Read edge lands on the edge that sets channel 1 pending.
        btn_a = 2'b10;
        repeat (6) tick();
        read_a = 1'b1;
        #1 chk("coll1_sample", op_a, 8'h00);
        tick();
        read_a = 1'b0;
        chk("coll1_after", op_a, 8'h02);
        btn_a = 2'b00;
        repeat (8) tick();
        btn_a = 2'b10;
        repeat (6) tick();
        read_a = 1'b1;
        #1 chk("coll2_sample", op_a, 8'h02);
        tick();
        read_a = 1'b0;
        chk("coll2_after", op_a, 8'h82);
        tick();
        read_a = 1'b1;
        tick();
        read_a = 1'b0;
        chk("coll2_clear", op_a, 8'h00);
        btn_a = 2'b00;
        repeat (6) tick();

        // Level mode, active low: btn=101 means only channel 1 is pressed.
        btn_b = 3'b101;
        repeat (5) tickc("lvl_early", 8'h00, 8'h00);
        tickc("lvl_press", 8'h00, 8'h02);
        for (int k = 0; k < 4; k++) begin
            read_b = ~read_b;
            tickc("lvl_read", 8'h00, 8'h02);
        end
        btn_b = 3'b111;
        repeat (5) tickc("lvl_hold", 8'h00, 8'h02);
        tickc("lvl_release", 8'h00, 8'h00);

        // Random bursts with varied hold lengths.
        repeat (60) begin
            btn_a  = 2'($urandom);
            btn_b  = 3'($urandom);
            read_a = ($urandom_range(0, 2) == 0);
            read_b = 1'($urandom);
            n = $urandom_range(1, 10);
            repeat (n) tick();
        end

        // Asynchronous reset with events likely pending.
        btn_a = 2'b11;
        read_a = 1'b0;
        repeat (8) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_a", op_a, 8'h00);
        chk("rst_mid_b", op_b, 8'h00);
        @(negedge clk);
        btn_a = 2'b00;
        btn_b = 3'b111;
        reset = 1'b1;
        repeat (10) tickc("post_rst", 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
